// File: rtl/cfg_stream_loader.sv
// Loads the state, per-stage config and inbound tables from a valid/ready beat stream,
// then gates a stream-in phase; config writes land in the bank opposite cfg_bank.
module cfg_stream_loader #(
    parameter int PHIT_SIZE = 512,
    parameter int NUM_STAGE = 6,
    parameter int ADDR_W    = 6,
    parameter int CTRL_W    = 24,
    parameter int IMM_W     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_loader,
    input  logic                 abort,
    input  logic [ADDR_W:0]      num_entry_state,
    input  logic [ADDR_W:0]      num_entry_config,
    input  logic [ADDR_W:0]      num_entry_inbound,
    input  logic [PHIT_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_en_state,
    output logic [NUM_STAGE-1:0] wr_en_cfg,
    output logic                 wr_en_inb,
    output logic [ADDR_W-1:0]    wr_add,
    output logic [CTRL_W-1:0]    wr_data_ctrl,
    output logic [IMM_W-1:0]     wr_data_imm,
    output logic [PHIT_SIZE-1:0] wr_data_phit,
    input  logic                 stream_valid,
    output logic                 ready_stream_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 cfg_bank
);
    localparam int STAGE_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
    localparam logic [ADDR_W:0]    ZERO_CNT   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]    ONE_CNT    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]    DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [STAGE_W-1:0] ZERO_STG   = {STAGE_W{1'b0}};
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_STATE = 3'd1,
        LD_CFG   = 3'd2,
        LD_INB   = 3'd3,
        STREAM   = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [ADDR_W:0]      idx_r, idx_s;
    logic [STAGE_W-1:0]   stage_r, stage_s;
    logic [ADDR_W:0]      cnt_state_r, cnt_cfg_r, cnt_inb_r, cur_cnt_s;
    logic                 capture_s, accept_s, last_s, over_s, write_s;
    logic                 wr_state_s, wr_inb_s, done_s, err_s;
    logic [NUM_STAGE-1:0] wr_cfg_s;

    // Phases with a zero count are skipped; STREAM always runs, even for zero beats.
    function automatic state_t first_phase(input logic [ADDR_W:0] n_state,
                                           input logic [ADDR_W:0] n_cfg,
                                           input logic [ADDR_W:0] n_inb);
        state_t ph;
        if (n_state != ZERO_CNT) begin
            ph = LD_STATE;
        end else if (n_cfg != ZERO_CNT) begin
            ph = LD_CFG;
        end else if (n_inb != ZERO_CNT) begin
            ph = LD_INB;
        end else begin
            ph = STREAM;
        end
        return ph;
    endfunction

    assign accept_s = in_valid && in_ready;
    assign over_s   = (num_entry_state > DEPTH) || (num_entry_config > DEPTH)
                   || (num_entry_inbound > DEPTH);
    assign write_s  = wr_state_s || wr_inb_s || (|wr_cfg_s);

    // Count of the table (or stream) currently being walked.
    always_comb begin
        case (state_r)
            LD_STATE: cur_cnt_s = cnt_state_r;
            LD_CFG:   cur_cnt_s = cnt_cfg_r;
            default:  cur_cnt_s = cnt_inb_r;
        endcase
    end

    assign last_s = (idx_r == (cur_cnt_s - ONE_CNT));

    // Next-state, entry counters and the write/status pulses for the coming cycle.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        stage_s    = stage_r;
        capture_s  = 1'b0;
        wr_state_s = 1'b0;
        wr_cfg_s   = {NUM_STAGE{1'b0}};
        wr_inb_s   = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
            idx_s   = ZERO_CNT;
            stage_s = ZERO_STG;
            err_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_loader && over_s) begin
                        err_s = 1'b1;
                    end else if (start_loader) begin
                        capture_s = 1'b1;
                        idx_s     = ZERO_CNT;
                        stage_s   = ZERO_STG;
                        state_s   = first_phase(num_entry_state, num_entry_config, num_entry_inbound);
                    end else begin
                        state_s = IDLE;
                    end
                end
                LD_STATE: begin
                    if (accept_s) begin
                        wr_state_s = 1'b1;
                        if (last_s) begin
                            idx_s   = ZERO_CNT;
                            state_s = first_phase(ZERO_CNT, cnt_cfg_r, cnt_inb_r);
                        end else begin
                            idx_s = idx_r + ONE_CNT;
                        end
                    end else begin
                        state_s = LD_STATE;
                    end
                end
                LD_CFG: begin
                    if (accept_s) begin
                        wr_cfg_s[stage_r] = 1'b1;
                        if (last_s && (stage_r == LAST_STAGE)) begin
                            idx_s   = ZERO_CNT;
                            stage_s = ZERO_STG;
                            state_s = first_phase(ZERO_CNT, ZERO_CNT, cnt_inb_r);
                        end else if (last_s) begin
                            idx_s   = ZERO_CNT;
                            stage_s = stage_r + {{(STAGE_W-1){1'b0}}, 1'b1};
                        end else begin
                            idx_s = idx_r + ONE_CNT;
                        end
                    end else begin
                        state_s = LD_CFG;
                    end
                end
                LD_INB: begin
                    if (accept_s) begin
                        wr_inb_s = 1'b1;
                        if (last_s) begin
                            idx_s   = ZERO_CNT;
                            state_s = STREAM;
                        end else begin
                            idx_s = idx_r + ONE_CNT;
                        end
                    end else begin
                        state_s = LD_INB;
                    end
                end
                STREAM: begin
                    if (cnt_inb_r == ZERO_CNT) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (stream_valid && ready_stream_in) begin
                        if (last_s) begin
                            done_s  = 1'b1;
                            idx_s   = ZERO_CNT;
                            state_s = IDLE;
                        end else begin
                            idx_s = idx_r + ONE_CNT;
                        end
                    end else begin
                        state_s = STREAM;
                    end
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = ZERO_CNT;
                    stage_s = ZERO_STG;
                end
            endcase
        end
    end

    // State register, entry/stage counters and captured counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= ZERO_CNT;
            stage_r     <= ZERO_STG;
            cnt_state_r <= ZERO_CNT;
            cnt_cfg_r   <= ZERO_CNT;
            cnt_inb_r   <= ZERO_CNT;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            stage_r <= stage_s;
            if (capture_s) begin
                cnt_state_r <= num_entry_state;
                cnt_cfg_r   <= num_entry_config;
                cnt_inb_r   <= num_entry_inbound;
            end
        end
    end

    // Registered outputs: handshakes follow the next state, writes trail the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready        <= 1'b0;
            ready_stream_in <= 1'b0;
            busy            <= 1'b0;
            wr_en_state     <= 1'b0;
            wr_en_cfg       <= {NUM_STAGE{1'b0}};
            wr_en_inb       <= 1'b0;
            wr_add          <= {ADDR_W{1'b0}};
            wr_data_ctrl    <= {CTRL_W{1'b0}};
            wr_data_imm     <= {IMM_W{1'b0}};
            wr_data_phit    <= {PHIT_SIZE{1'b0}};
            done            <= 1'b0;
            err             <= 1'b0;
            cfg_bank        <= 1'b0;
        end else begin
            in_ready        <= (state_s == LD_STATE) || (state_s == LD_CFG) || (state_s == LD_INB);
            ready_stream_in <= (state_s == STREAM);
            busy            <= (state_s != IDLE);
            wr_en_state     <= wr_state_s;
            wr_en_cfg       <= wr_cfg_s;
            wr_en_inb       <= wr_inb_s;
            done            <= done_s;
            err             <= err_s;
            if (done_s) begin
                cfg_bank <= ~cfg_bank;
            end
            if (write_s) begin
                wr_add       <= idx_r[ADDR_W-1:0];
                wr_data_ctrl <= in_data[PHIT_SIZE-1 -: CTRL_W];
                wr_data_imm  <= in_data[IMM_W-1:0];
                wr_data_phit <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: the driver queues the expected table write for
// every accepted beat and an independent monitor checks each write as it appears.
module tb_cfg_stream_loader;
    localparam int PS = 512;
    localparam int NS = 6;
    localparam int AW = 6;
    localparam int CW = 24;
    localparam int IW = 64;

    typedef struct packed {
        logic [7:0]    en;
        logic [AW-1:0] add;
        logic [PS-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start_loader, abort, in_valid, stream_valid;
    logic [AW:0]   num_entry_state, num_entry_config, num_entry_inbound;
    logic [PS-1:0] in_data;
    logic          in_ready, wr_en_state, wr_en_inb, ready_stream_in, busy, done, err, cfg_bank;
    logic [NS-1:0] wr_en_cfg;
    logic [AW-1:0] wr_add;
    logic [CW-1:0] wr_data_ctrl;
    logic [IW-1:0] wr_data_imm;
    logic [PS-1:0] wr_data_phit;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    bit   acc_prev = 1'b0;
    exp_t exp_q[$];

    cfg_stream_loader #(.PHIT_SIZE(PS), .NUM_STAGE(NS), .ADDR_W(AW), .CTRL_W(CW), .IMM_W(IW)) dut (
        .clk(clk), .rst(rst), .start_loader(start_loader), .abort(abort),
        .num_entry_state(num_entry_state), .num_entry_config(num_entry_config),
        .num_entry_inbound(num_entry_inbound), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en_state(wr_en_state), .wr_en_cfg(wr_en_cfg),
        .wr_en_inb(wr_en_inb), .wr_add(wr_add), .wr_data_ctrl(wr_data_ctrl),
        .wr_data_imm(wr_data_imm), .wr_data_phit(wr_data_phit), .stream_valid(stream_valid),
        .ready_stream_in(ready_stream_in), .busy(busy), .done(done), .err(err), .cfg_bank(cfg_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PS-1:0] mk_beat(input logic [15:0] tag, input int n);
        logic [31:0] w;
        w = {tag, n[15:0]};
        return {16{w}};
    endfunction

    // Beat order: state entries, then cfg stage 0..NS-1 (c each), then inbound entries.
    function automatic exp_t model(input int n, input int s, input int c, input logic [PS-1:0] d);
        exp_t e;
        int   m;
        e.data = d;
        e.en   = 8'd0;
        e.add  = '0;
        if (n < s) begin
            e.en[0] = 1'b1;
            e.add   = AW'(n);
        end else begin
            m = n - s;
            if (m < NS * c) begin
                e.en[1 + m / c] = 1'b1;
                e.add = AW'(m % c);
            end else begin
                e.en[7] = 1'b1;
                e.add   = AW'(m - NS * c);
            end
        end
        return e;
    endfunction

    // Monitor: a write must appear exactly one cycle after each accepted beat, and only then.
    always @(negedge clk) begin
        logic [7:0] en_act;
        exp_t       e;
        en_act = {wr_en_inb, wr_en_cfg, wr_en_state};
        if (done) done_cnt++;
        chk("rdy_excl", 512'(in_ready && ready_stream_in), 512'd0);
        if ((en_act != 8'd0) || acc_prev) begin
            chk("wr_timing", 512'(en_act != 8'd0), 512'(acc_prev));
            if (acc_prev && (exp_q.size() > 0)) begin
                e = exp_q.pop_front();
                chk("wr_en", 512'(en_act), 512'(e.en));
                chk("wr_add", 512'(wr_add), 512'(e.add));
                chk("wr_ctrl", 512'(wr_data_ctrl), 512'(e.data[PS-1 -: CW]));
                chk("wr_imm", 512'(wr_data_imm), 512'(e.data[IW-1:0]));
                chk("wr_phit", wr_data_phit, e.data);
            end
        end
        acc_prev = in_valid && in_ready && !rst && !abort;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the last beat.
    task automatic run_load(input int s, input int c, input int i, input bit toggle,
                            input int stop_at, input int abort_at, input logic [15:0] tag,
                            output int cycles);
        int n, cyc, total, lim, lim_exp;
        bit aborted;
        n = 0; cyc = 0; aborted = 1'b0;
        total = s + NS * c + i;
        lim = (stop_at < total) ? stop_at : total;
        lim_exp = ((abort_at >= 0) && (abort_at < lim)) ? abort_at : lim;
        num_entry_state   = s[AW:0];
        num_entry_config  = c[AW:0];
        num_entry_inbound = i[AW:0];
        start_loader = 1'b1;
        step();
        start_loader = 1'b0;
        while (!aborted && (n < lim) && (cyc < 4000)) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data  = mk_beat(tag, n);
            abort    = (n == abort_at) && in_valid;
            @(negedge clk);
            if (in_valid && in_ready && !abort) begin
                exp_q.push_back(model(n, s, c, in_data));
                n++;
            end
            step();
            cyc++;
            if (abort) begin
                aborted = 1'b1;
                abort   = 1'b0;
            end
        end
        in_valid = 1'b0;
        cycles = cyc;
        chk("load_beats", 512'(n), 512'(lim_exp));
    endtask

    task automatic run_stream(input int beats);
        int k, cyc;
        k = 0; cyc = 0;
        while ((k < beats) && (cyc < 500)) begin
            stream_valid = 1'b1;
            @(negedge clk);
            if (ready_stream_in) k++;
            step();
            cyc++;
        end
        stream_valid = 1'b0;
        chk("stream_beats", 512'(k), 512'(beats));
    endtask

    task automatic finish_stream(input string pfx, input logic exp_bank);
        @(negedge clk);
        chk({pfx, "_done"}, 512'(done), 512'd1);
        chk({pfx, "_bank"}, 512'(cfg_bank), 512'(exp_bank));
        chk({pfx, "_rdy_off"}, 512'(ready_stream_in), 512'd0);
        chk({pfx, "_busy_off"}, 512'(busy), 512'd0);
        step();
        @(negedge clk);
        chk({pfx, "_done_pulse"}, 512'(done), 512'd0);
        step();
    endtask

    task automatic full_load(input string pfx, input int s, input int c, input int i,
                             input bit toggle, input logic [15:0] tag, input int exp_cyc,
                             input logic exp_bank);
        int cyc;
        run_load(s, c, i, toggle, 1000, -1, tag, cyc);
        chk({pfx, "_cycles"}, 512'(cyc), 512'(exp_cyc));
        @(negedge clk);
        chk({pfx, "_rdy_stream"}, 512'(ready_stream_in), 512'd1);
        chk({pfx, "_in_ready"}, 512'(in_ready), 512'd0);
        chk({pfx, "_busy"}, 512'(busy), 512'd1);
        step();
        run_stream(i);
        finish_stream(pfx, exp_bank);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst = 1'b1; start_loader = 1'b0; abort = 1'b0; in_valid = 1'b0; stream_valid = 1'b0;
        in_data = '0; num_entry_state = '0; num_entry_config = '0; num_entry_inbound = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 512'({in_ready, wr_en_state, wr_en_cfg, wr_en_inb, wr_add,
                               ready_stream_in, busy, done, err, cfg_bank}), 512'd0);
        step();
        rst = 1'b0;
        step();

        full_load("full", 2, 2, 16, 1'b0, 16'h1111, 30, 1'b1);
        full_load("half", 2, 2, 16, 1'b1, 16'h2222, 59, 1'b0);
        full_load("skip", 1, 0, 4, 1'b0, 16'h3333, 5, 1'b1);

        // Oversized inbound count: error pulse, no load.
        num_entry_state = 7'd2; num_entry_config = 7'd2; num_entry_inbound = 7'd65;
        start_loader = 1'b1;
        step();
        start_loader = 1'b0;
        @(negedge clk);
        chk("ovf_err", 512'(err), 512'd1);
        chk("ovf_busy", 512'(busy), 512'd0);
        chk("ovf_in_ready", 512'(in_ready), 512'd0);
        step();
        @(negedge clk);
        chk("ovf_err_pulse", 512'(err), 512'd0);
        chk("ovf_busy2", 512'(busy), 512'd0);
        step();

        // Abort while a config beat is being accepted: that write is dropped.
        run_load(2, 2, 16, 1'b0, 1000, 4, 16'h4444, cyc);
        @(negedge clk);
        chk("abld_err", 512'(err), 512'd1);
        chk("abld_busy", 512'(busy), 512'd0);
        chk("abld_in_ready", 512'(in_ready), 512'd0);
        chk("abld_bank", 512'(cfg_bank), 512'd1);
        step();
        @(negedge clk);
        chk("abld_err_pulse", 512'(err), 512'd0);
        step();

        // Abort during STREAM after three beats.
        run_load(1, 0, 4, 1'b0, 1000, -1, 16'h5555, cyc);
        chk("abst_cycles", 512'(cyc), 512'd5);
        run_stream(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abst_err", 512'(err), 512'd1);
        chk("abst_rdy", 512'(ready_stream_in), 512'd0);
        chk("abst_bank", 512'(cfg_bank), 512'd1);
        chk("abst_busy", 512'(busy), 512'd0);
        chk("abst_done", 512'(done), 512'd0);
        step();

        // Reset after five config beats, then a clean reload.
        run_load(2, 2, 16, 1'b0, 7, -1, 16'h6666, cyc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ctl", 512'({in_ready, wr_en_state, wr_en_cfg, wr_en_inb, wr_add,
                              ready_stream_in, busy, done, err, cfg_bank}), 512'd0);
        chk("mrst_data", wr_data_phit | 512'(wr_data_ctrl) | 512'(wr_data_imm), 512'd0);
        step();
        full_load("reload", 2, 2, 16, 1'b0, 16'h7777, 30, 1'b1);

        chk("queue_empty", 512'(exp_q.size()), 512'd0);
        chk("done_count", 512'(done_cnt), 512'd4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
